// File: rtl/mem_access_unit_if.sv
// Request/response handshake and unified-memory port bundle for mem_access_unit.
// master = control FSM plus memory model side; slave = the sequencer itself.
interface mem_access_unit_if #(
  parameter int unsigned AddrW = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [AddrW-1:0] req_addr;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [31:0]      req_wdata;

  logic             rsp_valid;
  logic [31:0]      rsp_data;
  logic             rsp_misalign;

  logic [AddrW-1:0] mem_addr;
  logic             mem_rd_en;
  logic             mem_wr_en;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_misalign,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_be, mem_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_misalign,
    output mem_addr, mem_rd_en, mem_wr_en, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multicycle memory port sequencer: one load/store per request to a 1-cycle-latency memory.
// Define MISALIGN_TRAP_EN to report misaligned accesses instead of silently aligning them.
module mem_access_unit #(
  parameter int unsigned AddrW = 32
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StData, StResp} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [AddrW-1:0] acc_addr;
  logic             mis_req;
  logic [31:0]      shifted;
  logic [31:0]      load_data;
  logic [3:0]       be;

`ifdef MISALIGN_TRAP_EN
  logic mis_q, mis_d;

  always_comb begin
    acc_addr = bus.req_addr;
    mis_req  = ((bus.req_size == 2'b01) & bus.req_addr[0]) |
               (bus.req_size[1] & (|bus.req_addr[1:0]));
  end
`else
  // Without the trap, misaligned requests are quietly rounded down to natural alignment.
  always_comb begin
    acc_addr = bus.req_addr;
    mis_req  = 1'b0;
    if (bus.req_size == 2'b01) acc_addr[0] = 1'b0;
    if (bus.req_size[1])       acc_addr[1:0] = 2'b00;
  end
`endif

  always_comb begin
    shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00:   be = 4'b0001 << addr_q[1:0];
      2'b01:   be = 4'b0011 << {addr_q[1], 1'b0};
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
`ifdef MISALIGN_TRAP_EN
    mis_d      = mis_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          addr_d  = acc_addr;
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          wdata_d = bus.req_wdata;
`ifdef MISALIGN_TRAP_EN
          mis_d   = mis_req;
`endif
          if (mis_req) begin
            rsp_data_d = 32'h0;
            state_d    = StResp;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (we_q) begin
          rsp_data_d = 32'h0;
          state_d    = StResp;
        end else begin
          state_d = StData;
        end
      end
      StData: begin
        rsp_data_d = load_data;
        state_d    = StResp;
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      wdata_q    <= 32'h0;
      rsp_data_q <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
`ifdef MISALIGN_TRAP_EN
      mis_q      <= mis_d;
`endif
    end
  end

  // Strobes decode straight from state so an async reset kills them at once.
  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_data  = rsp_data_q;
`ifdef MISALIGN_TRAP_EN
    bus.rsp_misalign = (state_q == StResp) & mis_q;
`else
    bus.rsp_misalign = 1'b0;
`endif
    bus.mem_addr  = {addr_q[AddrW-1:2], 2'b00};
    bus.mem_rd_en = (state_q == StAccess) & ~we_q;
    bus.mem_wr_en = (state_q == StAccess) & we_q;
    bus.mem_be    = bus.mem_wr_en ? be : 4'b0000;
    case (size_q)
      2'b00:   bus.mem_wdata = {4{wdata_q[7:0]}};
      2'b01:   bus.mem_wdata = {2{wdata_q[15:0]}};
      default: bus.mem_wdata = wdata_q;
    endcase
  end

endmodule
